sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port request arbiter and access sequencer for the 512x8 behavioural SRAM. It accepts read and write requests from two requesters, such as the cache fill path (port 0) and the CPU-side lookup (port 1). It grants one request at a time and drives the SRAM strobes `sense_en`/`wen`, `addr` and `din`. It waits the configured read latency, then returns read data as a single-cycle response pulse to the granted port.

## Interface

Parameters:
- `ADDR_W`, 9: SRAM address width.
- `DATA_W`, 8: SRAM data width.
- `READ_LAT`, 2: cycles from the edge that samples `mem_sense_en` to the edge that captures `mem_dout`. Legal range is 1..15.

Ports:
- Clocking and reset:
  - `clk` input 1: single clock; all state updates on the rising edge.
  - `rst` input 1: asynchronous, active-high reset.
- Requester ports (`i` = 0, 1):
  - `req{i}_valid` input 1: request pending.
  - `req{i}_ready` output 1: request accepted this cycle.
  - `req{i}_we` input 1: 1 = write, 0 = read.
  - `req{i}_addr` input ADDR_W: target address.
  - `req{i}_wdata` input DATA_W: write data.
- Response ports (`i` = 0, 1):
  - `rsp{i}_valid` output 1: one-cycle response pulse.
  - `rsp{i}_rdata` output DATA_W: read data, valid with `rsp{i}_valid`.
- SRAM side:
  - `mem_sense_en` output 1: SRAM read strobe.
  - `mem_wen` output 1: SRAM write strobe.
  - `mem_addr` output ADDR_W: SRAM address.
  - `mem_din` output DATA_W: SRAM write data.
  - `mem_dout` input DATA_W: SRAM read data.
- Status:
  - `busy` output 1: high whenever state is not IDLE.

## Operation

- FSM states and transitions:
  - IDLE: `req{i}_ready` is high, combinationally, for the granted port only, and only while that port's valid is high. A handshake (valid & ready) latches `we`/`addr`/`wdata` and the port index, then goes to ISSUE.
  - ISSUE: exactly one of `mem_wen`/`mem_sense_en` is high for one cycle; both are registered outputs. A write goes to RESP. A read goes to WAIT with the counter loaded to READ_LAT.
  - WAIT: the counter decrements each cycle. On the cycle the counter reaches 1, `mem_dout` is captured into the response register, then go to RESP.
  - RESP: `rsp{port}_valid` is high for one cycle, then go to IDLE.
- Response data:
  - For a write, `rsp_rdata` holds its previous value; the response acknowledges the write only.
  - `rsp{i}_rdata` of the non-granted port is unchanged.
- Requester rules:
  - No backpressure on responses; the requester must take the pulse.
  - A requester holds valid and its fields stable until ready.
  - Deasserting valid before ready is legal; the request is simply not taken.
- Arbitration is decided in IDLE only. It applies when both valids are high (see Configuration). A single valid is always granted.
- `mem_addr`/`mem_din` hold the latched request from ISSUE until the next accept. They are never X after reset.
- Addresses cover the full 0..2^ADDR_W-1 range. There is no wrap or range check.
- Reset mid-operation:
  - State goes to IDLE and all outputs go to 0 immediately.
  - An in-flight read response is discarded.
  - A pending `mem_wen` drops with reset.

## Timing

- Reset values:
  - all `req{i}_ready`, `rsp{i}_valid`, `mem_sense_en`, `mem_wen`, `busy` = 0;
  - `mem_addr`, `mem_din`, `rsp{i}_rdata` = 0;
  - round-robin pointer = 1, so port 0 wins the first tie.
- Handshake in cycle c:
  - ISSUE (strobe high) in cycle c+1.
  - Read: WAIT during cycles c+2..c+1+READ_LAT; `rsp_valid` in cycle c+2+READ_LAT; ready again at c+3+READ_LAT.
  - Write: `rsp_valid` in cycle c+2; ready again at c+3.
- Throughput: one read per READ_LAT+3 cycles, one write per 3 cycles.
- `busy` rises the cycle after accept and falls on the cycle IDLE is re-entered.

## Configuration

- `SRAM_ARB_RR_EN` defined:
  - Round-robin arbitration. When both ports are valid, grant the port not granted last.
  - The pointer updates on each accepted handshake.
- `SRAM_ARB_RR_EN` undefined:
  - Fixed priority: port 0 always wins ties.
  - Port 1 is served only when `req0_valid` is low in IDLE.
  - The pointer logic is removed.

## Test plan

- Reset, then hold `rst` mid-test → all outputs are 0 asynchronously, before the next edge. After release, port 0 wins the first tie.
- Port 0 writes 0xA5 to address 0x1FF, then reads 0x1FF (READ_LAT=2):
  - `mem_wen` is high one cycle after the first handshake;
  - `rsp0_valid` for the write arrives 2 cycles after its handshake;
  - `rsp0_valid` with `rsp0_rdata`=0xA5 arrives 4 cycles after the read handshake.
- Both ports valid continuously with reads:
  - with `SRAM_ARB_RR_EN` defined, grants alternate 0,1,0,1;
  - without it, the grants are 0,0,0,0 and `req1_ready` never rises.
- `req1_valid` alone, write 0x3C to address 0, then port 0 reads address 0 → `rsp1_valid` pulses once with `rsp0_valid` low, then `rsp0_rdata`=0x3C.
- Assert `rst` during WAIT of a read → no `rsp_valid` pulse. `busy` is 0 and `req0_ready` is high on the first cycle after release with `req0_valid` high.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port request arbiter and access sequencer for a 512x8 SRAM with fixed read latency.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module sram_arbiter #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              mem_sense_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,

    output logic              busy
);

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lat_we_q;
    logic             lat_port_q;

    logic             grant_c;
    logic             accept_c;
    logic             capture_c;
    req_t             sel_c;

    // Tie-break between simultaneous requests; a lone valid always wins.
`ifdef SRAM_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept_c) begin
            last_q <= grant_c;
        end
    end

    always_comb begin
        grant_c = ~req0_valid;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_q;
        end
    end
`else
    always_comb begin
        grant_c = ~req0_valid;
    end
`endif

    // Ready is combinational and forced low while reset is asserted.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && state_q == IDLE) begin
            req0_ready = req0_valid & ~grant_c;
            req1_ready = req1_valid &  grant_c;
        end
    end

    always_comb begin
        accept_c = req0_ready | req1_ready;
        sel_c    = grant_c ? req_t'{we: req1_we, addr: req1_addr, wdata: req1_wdata}
                           : req_t'{we: req0_we, addr: req0_addr, wdata: req0_wdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_we_q) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(READ_LAT);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    capture_c = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered SRAM strobes, address/data hold, response pulse and capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we_q     <= 1'b0;
            lat_port_q   <= 1'b0;
            mem_sense_en <= 1'b0;
            mem_wen      <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp0_rdata   <= '0;
            rsp1_rdata   <= '0;
            busy         <= 1'b0;
        end else begin
            mem_sense_en <= accept_c & ~sel_c.we;
            mem_wen      <= accept_c &  sel_c.we;
            busy         <= (state_d != IDLE);
            rsp0_valid   <= (state_d == RESP) && !lat_port_q;
            rsp1_valid   <= (state_d == RESP) &&  lat_port_q;
            if (accept_c) begin
                lat_we_q   <= sel_c.we;
                lat_port_q <= grant_c;
                mem_addr   <= sel_c.addr;
                mem_din    <= sel_c.wdata;
            end
            if (capture_c) begin
                if (lat_port_q) begin
                    rsp1_rdata <= mem_dout;
                end else begin
                    rsp0_rdata <= mem_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: transaction-timeline model plus directed scenarios.
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned READ_LAT = 2;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid = 1'b0, req0_we = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_wdata = '0;
    logic              req1_valid = 1'b0, req1_we = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_wdata = '0;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              mem_sense_en, mem_wen, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_sense_en(mem_sense_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural SRAM: data appears on mem_dout only on the capture cycle.
    logic [DATA_W-1:0] sram [512];
    logic [DATA_W-1:0] pend_data = '0;
    int                pend_cnt = 0;
    always @(posedge clk) begin
        if (mem_wen) sram[mem_addr] <= mem_din;
        if (mem_sense_en) begin
            pend_data <= sram[mem_addr];
            pend_cnt  <= int'(READ_LAT);
        end else if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
        end
    end
    assign mem_dout = (pend_cnt == 1) ? pend_data : 8'hEE;

    // Timeline model: an accept at cycle c fixes the strobe, response and idle cycles.
    logic [DATA_W-1:0] shadow [512];
    int                free_at = 0, issue_cyc = -1, rsp_cyc = -1;
    bit                cur_we = 1'b0, cur_port = 1'b0, last_g = 1'b1;
    logic [ADDR_W-1:0] cur_addr = '0, e_addr = '0;
    logic [DATA_W-1:0] cur_wd = '0, e_din = '0, e_rd0 = '0, e_rd1 = '0;
    bit                m_idle, m_g, er0, er1;
    int                gq[$];

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready0", 32'(req0_ready), 32'd0);
            chk("rst_ready1", 32'(req1_ready), 32'd0);
            chk("rst_rsp0", 32'(rsp0_valid), 32'd0);
            chk("rst_rsp1", 32'(rsp1_valid), 32'd0);
            chk("rst_sense", 32'(mem_sense_en), 32'd0);
            chk("rst_wen", 32'(mem_wen), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_addr", 32'(mem_addr), 32'd0);
            chk("rst_din", 32'(mem_din), 32'd0);
            chk("rst_rd0", 32'(rsp0_rdata), 32'd0);
            chk("rst_rd1", 32'(rsp1_rdata), 32'd0);
            free_at = 0; issue_cyc = -1; rsp_cyc = -1; last_g = 1'b1;
            e_addr = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0;
        end else begin
            m_idle = (cyc >= free_at);
            if (req0_valid && req1_valid) m_g = RR ? !last_g : 1'b0;
            else                          m_g = !req0_valid;
            er0 = m_idle && req0_valid && !m_g;
            er1 = m_idle && req1_valid &&  m_g;
            if (cyc == issue_cyc) begin
                e_addr = cur_addr;
                e_din  = cur_wd;
            end
            if (cyc == rsp_cyc && !cur_we) begin
                if (cur_port) e_rd1 = shadow[cur_addr];
                else          e_rd0 = shadow[cur_addr];
            end
            chk("ready0", 32'(req0_ready), 32'(er0));
            chk("ready1", 32'(req1_ready), 32'(er1));
            chk("busy", 32'(busy), 32'(!m_idle));
            chk("sense_en", 32'(mem_sense_en), 32'(cyc == issue_cyc && !cur_we));
            chk("wen", 32'(mem_wen), 32'(cyc == issue_cyc && cur_we));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_din", 32'(mem_din), 32'(e_din));
            chk("rsp0_valid", 32'(rsp0_valid), 32'(cyc == rsp_cyc && !cur_port));
            chk("rsp1_valid", 32'(rsp1_valid), 32'(cyc == rsp_cyc && cur_port));
            chk("rsp0_rdata", 32'(rsp0_rdata), 32'(e_rd0));
            chk("rsp1_rdata", 32'(rsp1_rdata), 32'(e_rd1));
            if (er0 || er1) begin
                cur_port  = er1;
                cur_we    = er1 ? req1_we : req0_we;
                cur_addr  = er1 ? req1_addr : req0_addr;
                cur_wd    = er1 ? req1_wdata : req0_wdata;
                issue_cyc = cyc + 1;
                rsp_cyc   = cyc + 2 + (cur_we ? 0 : int'(READ_LAT));
                free_at   = rsp_cyc + 1;
                last_g    = cur_port;
                gq.push_back(int'(cur_port));
                if (cur_we) shadow[cur_addr] = cur_wd;
            end
        end
    end

    task automatic drive(input bit p, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        if (p) begin req1_we = we; req1_addr = a; req1_wdata = d; req1_valid = 1'b1; end
        else   begin req0_we = we; req0_addr = a; req0_wdata = d; req0_valid = 1'b1; end
    endtask

    // Present a request, wait for its handshake, then drop valid after the edge.
    task automatic issue(input bit p, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output int hs);
        hs = -1;
        drive(p, we, a, d);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (p ? req1_ready : req0_ready) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) chk("handshake_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit p, output int rc, output logic [DATA_W-1:0] rd,
                            output bit other);
        rc = -1; rd = '0; other = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (p ? rsp1_valid : rsp0_valid) begin
                rc = cyc;
                rd = p ? rsp1_rdata : rsp0_rdata;
                other = p ? rsp0_valid : rsp1_valid;
                break;
            end
        end
        if (rc < 0) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy && !rsp0_valid && !rsp1_valid) break;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int                hs, hs2, rc;
    logic [DATA_W-1:0] rd;
    bit                oth, r1_seen;
    int                g_exp [4];

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram[i]   = '0;
            shadow[i] = '0;
        end

        // Reset with both requesters already valid.
        drive(1'b0, 1'b0, 9'h010, 8'h00);
        drive(1'b1, 1'b0, 9'h020, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("lit_reset_ready0", 32'(req0_ready), 32'd0);
        chk("lit_reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Both ports valid continuously: first tie goes to port 0.
        r1_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (req1_ready) r1_seen = 1'b1;
            if (gq.size() >= 4) break;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        g_exp = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
        chk("lit_tie_count", 32'(gq.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) chk("lit_tie_grant", 32'(gq[i]), 32'(g_exp[i]));
        end
        if (!RR) chk("lit_fixed_no_ready1", 32'(r1_seen), 32'd0);
        wait_idle();

        // Port 0 writes 0xA5 to 0x1FF, then reads it back.
        issue(1'b0, 1'b1, 9'h1FF, 8'hA5, hs);
        chk("lit_wen_c1", 32'(mem_wen), 32'd1);
        chk("lit_wen_cyc", 32'(cyc), 32'(hs + 1));
        wait_rsp(1'b0, rc, rd, oth);
        chk("lit_wr_rsp_lat", 32'(rc - hs), 32'd2);
        wait_idle();
        issue(1'b0, 1'b0, 9'h1FF, 8'h00, hs);
        wait_rsp(1'b0, rc, rd, oth);
        chk("lit_rd_rsp_lat", 32'(rc - hs), 32'd4);
        chk("lit_rd_data_a5", 32'(rd), 32'hA5);
        wait_idle();

        // Port 1 alone writes 0x3C to address 0; port 0 then reads it.
        issue(1'b1, 1'b1, 9'h000, 8'h3C, hs);
        wait_rsp(1'b1, rc, rd, oth);
        chk("lit_p1_wr_lat", 32'(rc - hs), 32'd2);
        chk("lit_p1_rsp0_low", 32'(oth), 32'd0);
        wait_idle();
        issue(1'b0, 1'b0, 9'h000, 8'h00, hs);
        wait_rsp(1'b0, rc, rd, oth);
        chk("lit_rd_data_3c", 32'(rd), 32'h3C);
        wait_idle();

        // Asynchronous reset while the write strobe is up.
        issue(1'b0, 1'b1, 9'h055, 8'h77, hs);
        chk("lit_wen_before_rst", 32'(mem_wen), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("lit_async_wen", 32'(mem_wen), 32'd0);
        chk("lit_async_busy", 32'(busy), 32'd0);
        chk("lit_async_addr", 32'(mem_addr), 32'd0);
        chk("lit_async_rd0", 32'(rsp0_rdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle();

        // Reset during WAIT of a read; release with both ports valid.
        issue(1'b0, 1'b0, 9'h1FF, 8'h00, hs);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 9'h1FF, 8'h00);
        drive(1'b1, 1'b0, 9'h000, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("lit_release_ready0", 32'(req0_ready), 32'd1);
        chk("lit_release_ready1", 32'(req1_ready), 32'd0);
        chk("lit_release_busy", 32'(busy), 32'd0);
        @(negedge clk);
        hs2 = cyc;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(1'b0, rc, rd, oth);
        chk("lit_post_rst_lat", 32'(rc - hs2), 32'd4);
        chk("lit_post_rst_data", 32'(rd), 32'hA5);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
